// File: rtl/rr_burst_mux.sv
// Burst-locking consumer for a round-robin arbiter: forwards valids as requests,
// locks the granted requester onto the shared output stream until its burst ends.
module rr_burst_mux #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          in_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data_i,
    input  logic [NUM_REQ-1:0]          in_last_i,
    output logic [NUM_REQ-1:0]          in_ready_o,
    output logic [NUM_REQ-1:0]          arb_req_o,
    input  logic [NUM_REQ-1:0]          arb_gnt_i,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        busy_o,
    output logic                        err_o
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            err_reg, err_next;

    logic [DATA_W-1:0] slice [NUM_REQ];
    logic [OW-1:0]     gnt_idx;
    logic              gnt_onehot, gnt_valid;
    logic              busy, own_valid, own_last, beat_cap, last_int, xfer;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign slice[gi] = in_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt_i[k]) gnt_idx = OW'(k);
        end
    end

    assign gnt_onehot = (arb_gnt_i != '0) && ((arb_gnt_i & (arb_gnt_i - GNT_ONE)) == '0);
    assign gnt_valid  = gnt_onehot && ((arb_gnt_i & in_valid_i) != '0);

    assign busy      = (state_reg == BUSY);
    assign own_valid = in_valid_i[owner_reg];
    assign own_last  = in_last_i[owner_reg];
    // The MAX_BEATS-th beat closes the burst whether or not the source marks it.
    assign beat_cap  = (count_reg == CW'(MAX_BEATS - 1));
    assign last_int  = own_last | beat_cap;
    assign xfer      = busy & own_valid & out_ready_i;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        count_next = count_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    owner_next = gnt_idx;
                    count_next = '0;
                    state_next = BUSY;
                end else if (arb_gnt_i != '0) begin
                    err_next = 1'b1;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (last_int) begin
                        state_next = IDLE;
                        owner_next = '0;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Every output is gated by rst_ni so reset forces zeros even on the combinational paths.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign in_ready_o[gi] = rst_ni & busy & out_ready_i & (owner_reg == OW'(gi));
        end
    endgenerate

    assign arb_req_o   = (rst_ni && !busy) ? in_valid_i : '0;
    assign out_valid_o = rst_ni & busy & own_valid;
    assign out_data_o  = (rst_ni && busy) ? slice[owner_reg] : '0;
    assign out_last_o  = rst_ni & busy & last_int;
    assign owner_o     = (rst_ni && busy) ? owner_reg : '0;
    assign busy_o      = rst_ni & busy;
    assign err_o       = rst_ni & err_reg;

endmodule

// File: doc/rr_burst_mux.md
Name: rr_burst_mux

Overview:
- Consumer stage placed directly downstream of rr_arbiter; also drives that arbiter's request vector.
- Presents per-requester valid signals to the arbiter as requests.
- Captures the arbiter's one-hot grant and locks ownership of a shared valid/ready output stream until the granted requester's burst ends (last beat, or MAX_BEATS reached).
- Muxes the owner's data and last signals onto the output.

Parameters:
- NUM_REQ, 4, number of requesters; must match the arbiter's NUM_REQ; ≥2.
- DATA_W, 32, payload width.
- MAX_BEATS, 16, maximum beats per locked burst before forced release; ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  NUM_REQ  per-requester valid.
- in_data_i  in  NUM_REQ*DATA_W  packed payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- in_last_i  in  NUM_REQ  per-requester end-of-burst marker.
- in_ready_o  out  NUM_REQ  per-requester ready.
- arb_req_o  out  NUM_REQ  request vector to the arbiter's req_i.
- arb_gnt_i  in  NUM_REQ  one-hot grant from the arbiter's gnt_o.
- out_valid_o  out  1  output stream valid.
- out_data_o  out  DATA_W  output payload.
- out_last_o  out  1  output end-of-burst marker.
- out_ready_i  in  1  downstream ready.
- owner_o  out  $clog2(NUM_REQ)  index of the locked requester; 0 when idle.
- busy_o  out  1  a grant is locked.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset: asynchronous on rst_ni low. State=IDLE; owner=0; beat count=0; err_o=0. All outputs 0 while reset is asserted, including mid-burst. Any in-flight burst is abandoned; no beat is completed during reset.
- States: IDLE and BUSY.
- IDLE:
  - arb_req_o = in_valid_i; in_ready_o = 0; out_valid_o = 0; busy_o = 0.
  - A grant is valid when arb_gnt_i is exactly one-hot and in_valid_i at that bit is 1.
  - On a valid grant at a rising edge: latch owner = bit index, clear beat count, go to BUSY.
  - The first beat can transfer in the next cycle, so grant-to-first-beat latency is 1 cycle.
  - Invalid grant condition: arb_gnt_i is nonzero but either not one-hot or pointing at a non-valid requester. Set err_o=1 (sticky until reset) and stay in IDLE.
  - arb_gnt_i == 0 is not an error.
- BUSY:
  - arb_req_o = 0, so the arbiter sees no requests while the grant is locked.
  - busy_o = 1; owner_o = owner.
  - out_valid_o = in_valid_i[owner]; out_data_o = owner's slice of in_data_i.
  - in_ready_o = one-hot(owner) & out_ready_i; non-owner readies are 0.
  - Beat transfer = out_valid_o & out_ready_i, at zero-cycle throughput; back-to-back beats are allowed every cycle.
  - The beat count increments on each transfer. Count width is $clog2(MAX_BEATS+1); it never wraps.
  - out_last_o = in_last_i[owner] OR (beat count == MAX_BEATS-1). At the MAX_BEATS-th beat, last is forced high even if the requester did not assert it.
  - On a transfer with out_last_o=1: go to IDLE. The next arbitration happens in the following cycle, so there is 1 idle bubble between bursts.
  - When last is forced by MAX_BEATS, the requester's remaining beats must re-arbitrate as a new burst.
  - If the owner drops valid mid-burst, the lock is held and out_valid_o=0. No timeout.
- Combinational paths: arb_gnt_i → state only (registered). in_valid_i/in_data_i/out_ready_i → outputs combinationally in BUSY. No combinational loop with the arbiter, because arb_req_o depends only on state and in_valid_i.
- Outputs are never X after reset; out_data_o = 0 when idle.

Test Plan:
- Reset, then in_valid_i=4'b0100, arbiter grants 4'b0100, 3-beat burst (data A1,A2,A3; last on A3), out_ready_i=1 → busy_o rises 1 cycle after grant. out_data_o = A1,A2,A3 on consecutive cycles. in_ready_o=4'b0100 during BUSY. Return to IDLE after A3; arb_req_o=0 while busy.
- MAX_BEATS=4, requester 1 streams 6 beats with no last → out_last_o=1 on beat 4, release to IDLE. The re-grant to requester 1 delivers beats 5–6 as a new burst.
- All four requesters valid with rr_arbiter connected, each sending 2-beat bursts → owner_o sequence covers all of 0..3 with no starvation. Output beats are never interleaved between requesters.
- Downstream backpressure: out_ready_i toggles 1,0,0,1 mid-burst → data held stable while stalled, no beat lost or duplicated, and the beat count advances only on transfers.
- Invalid grant: arb_gnt_i=4'b0011, or 4'b1000 while in_valid_i[3]=0 → err_o=1 and sticky, state stays IDLE. Only reset clears err_o.
- rst_ni asserted asynchronously mid-burst (between clock edges) → all outputs 0 immediately. After release, IDLE with err_o=0, and a new grant is required before any output.
